scene_animator: RTL and testbench
=================================

# scene_animator

Parametrised scene generator that replaces the fixed-constant stimulus feeding `display_module`. It animates N pipes and one bird once per video frame: scrolling, wrap-around, pseudo-random gap centres, level-dependent speed and gap, bird gravity and flap, sprite frame cycling, and score counting. Outputs are flat packed buses that wire straight into the display's pipe, bird and score inputs.

## Interface
- `N_PIPES`, 3, number of pipe channels (1–8)
- `PIPE_SPACING`, 200, horizontal distance between adjacent pipes at reset (px)
- `INIT_X`, 300, reset position of pipe 0 (px)
- `CENTER_MIN`, 120, lowest generated gap centre; the centre is `CENTER_MIN + lfsr[6:0]`
- `GAP_BASE`, 100, gap at level 0 (px)
- `GAP_STEP`, 16, gap reduction per level
- `BIRD_H`, 200, fixed bird horizontal position; also the score line
- `BIRD_V0`, 150, bird reset/start height
- `V_MAX_POS`, 440, lowest allowed bird_v
- `GRAVITY`, 1, velocity increment per frame
- `FLAP_V`, 8, upward velocity magnitude applied on flap
- `VEL_MAX`, 10, downward velocity clamp
- `ANIM_DIV`, 6, frames per bird sprite step

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `frame_tick` in 1: one-cycle pulse per frame (VS edge)
- `start` in 1: level-sensitive start / restart request
- `pause` in 1: level-sensitive freeze
- `hit` in 1: collision from the display/collision logic
- `flap` in 1: one-cycle flap request
- `level` in 2: difficulty, 0–3
- `pipe_pos` out 11*N_PIPES: pipe i in bits [11i+10:11i]
- `pipe_center` out 11*N_PIPES
- `pipe_gap` out 11*N_PIPES
- `bird_v` out 11
- `bird_state` out 3: sprite frame 0–3
- `score` out 8
- `game_state` out 2: 0 IDLE, 1 RUN, 2 PAUSED, 3 OVER

## Operation
- Reset values for all outputs:
  - `pipe_pos[i] = INIT_X + i*PIPE_SPACING`
  - `pipe_center[i] = CENTER_MIN + 64`
  - `pipe_gap[i] = GAP_BASE`
  - `bird_v = BIRD_V0`, `bird_state = 0`, `score = 0`, `game_state = IDLE`
- Reset also clears velocity, the flap latch and the anim counter, and sets the 16-bit LFSR to 16'hACE1.
- FSM:
  - IDLE→RUN on `start`; every register except the LFSR is reinitialised to its reset value on entry.
  - RUN→OVER on `hit`.
  - RUN→PAUSED on `pause`; PAUSED→RUN on `!pause`.
  - OVER→IDLE on `start`.
  - `hit` has priority over `pause` in RUN.
- Updates happen only on `frame_tick` in RUN. In IDLE, PAUSED and OVER, all outputs hold.
- The LFSR (taps 16,14,13,11) advances every clk in all states, giving seed entropy from the `start` timing.
- Scroll: `speed = level + 1`. For each pipe:
  - if `pos >= speed`: `pos <= pos - speed`
  - otherwise (wrap): `pos <= pos + N_PIPES*PIPE_SPACING - speed`, `center <= CENTER_MIN + lfsr[6:0]`, `gap <= GAP_BASE - level*GAP_STEP`
- Pipes are processed in the same cycle. Multiple simultaneous wraps use the same LFSR bits plus the pipe index XOR (`lfsr[6:0] ^ i`).
- Score: +1 for each pipe with `old_pos >= BIRD_H && new_pos < BIRD_H` in that frame. Several crossings in one frame add their count. Score saturates at 255.
- Bird:
  - A `flap` pulse sets a latch, which is consumed at the next frame_tick in RUN.
  - If latched: `vel <= -FLAP_V`; else `vel <= min(vel + GRAVITY, VEL_MAX)`.
  - `vel` is signed 6-bit.
  - `bird_v <= clamp(bird_v + vel, 0, V_MAX_POS)`, using the old `vel`. The sum is computed signed in 12 bits before clamping.
- Sprite: the anim counter counts frame_ticks in RUN. At `ANIM_DIV-1` it clears and `bird_state` steps 0→1→2→3→0.

## Timing
- All outputs are registered. The new values are visible the cycle after the `frame_tick` that caused them (latency 1).
- FSM transitions take effect the cycle after the input is sampled.
- A `frame_tick` coincident with `hit` in RUN: no motion update, and the state goes to OVER.
- A `frame_tick` coincident with the IDLE→RUN transition: reinit only, no motion.
- A `flap` coincident with `frame_tick`: applied in that same update.
- `rst` mid-game overrides everything in one cycle.

## Test plan
- Reset, `start`, level 0, 5 frame_ticks -> `pipe_pos` = 295/495/695, `bird_v` = 150+0+1+2+3+4 = 160, `score` = 0.
- Level 3, pipe 0 at pos 2, one tick -> pos = 2+600-4 = 598, new centre in [120,247], gap = 52.
- Pipe 0 moving 201→200→199 at level 0 -> score increments exactly once, on the 200→199 step. Force score to 255 plus another crossing -> stays 255.
- `flap` with bird_v=150, vel=3, then tick -> bird_v=153, vel=-8. Next tick -> bird_v=145. Bird at 5 with vel=-8 -> clamps to 0. At 438 with vel=10 -> clamps to 440.
- `pause` for 10 ticks -> all outputs constant, `game_state`=2. `hit` and `pause` together from RUN -> `game_state`=3. `start` from OVER -> IDLE, and `start` again -> reset positions.
- N_PIPES=5 build, 12 ticks at ANIM_DIV=6 -> `bird_state` = 2, and all 5 bus slices scroll.

Source files
------------

// File: rtl/scene_animator.sv
// Per-frame scene generator: scrolls N pipes with LFSR-seeded gap centres, runs bird
// gravity/flap physics, cycles the bird sprite and counts score for the display block.
module scene_animator #(
   parameter int N_PIPES      = 3,
   parameter int PIPE_SPACING = 200,
   parameter int INIT_X       = 300,
   parameter int CENTER_MIN   = 120,
   parameter int GAP_BASE     = 100,
   parameter int GAP_STEP     = 16,
   parameter int BIRD_H       = 200,
   parameter int BIRD_V0      = 150,
   parameter int V_MAX_POS    = 440,
   parameter int GRAVITY      = 1,
   parameter int FLAP_V       = 8,
   parameter int VEL_MAX      = 10,
   parameter int ANIM_DIV     = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_tick,
   input  logic                   start,
   input  logic                   pause,
   input  logic                   hit,
   input  logic                   flap,
   input  logic [1:0]             level,
   output logic [11*N_PIPES-1:0]  pipe_pos,
   output logic [11*N_PIPES-1:0]  pipe_center,
   output logic [11*N_PIPES-1:0]  pipe_gap,
   output logic [10:0]            bird_v,
   output logic [2:0]             bird_state,
   output logic [7:0]             score,
   output logic [1:0]             game_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      OVER   = 2'd3
   } state_t;

   localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [AW-1:0]       ANIM_LAST = AW'(ANIM_DIV - 1);
   localparam logic [10:0]         RING      = 11'(N_PIPES * PIPE_SPACING);
   localparam logic [10:0]         SCORE_X   = 11'(BIRD_H);
   localparam logic [10:0]         BIRD_MAX  = 11'(V_MAX_POS);
   localparam logic signed [5:0]   FLAP_VEL  = 6'(-FLAP_V);
   localparam logic signed [6:0]   VMAX7     = 7'(VEL_MAX);

   function automatic logic [11*N_PIPES-1:0] init_pos();
      logic [11*N_PIPES-1:0] v;
      v = '0;
      for (int i = 0; i < N_PIPES; i++) begin
         v[11*i +: 11] = 11'(INIT_X + i * PIPE_SPACING);
      end
      return v;
   endfunction

   localparam logic [11*N_PIPES-1:0] POS_INIT    = init_pos();
   localparam logic [11*N_PIPES-1:0] CENTER_INIT = {N_PIPES{11'(CENTER_MIN + 64)}};
   localparam logic [11*N_PIPES-1:0] GAP_INIT    = {N_PIPES{11'(GAP_BASE)}};

   state_t                state;
   logic [15:0]           lfsr;
   logic signed [5:0]     vel;
   logic                  flap_latch;
   logic [AW-1:0]         anim_cnt;

   logic [10:0]           speed;
   logic [10:0]           gap_new;
   logic [11*N_PIPES-1:0] pos_nxt;
   logic [11*N_PIPES-1:0] center_nxt;
   logic [11*N_PIPES-1:0] gap_nxt;
   logic [3:0]            cross_cnt;
   logic [8:0]            score_sum;
   logic [7:0]            score_nxt;
   logic signed [6:0]     vel_inc;
   logic signed [5:0]     vel_nxt;
   logic signed [11:0]    bird_sum;
   logic [10:0]           bird_nxt;
   logic                  reinit;
   logic                  do_update;

   assign reinit     = rst || (state == IDLE && start);
   assign do_update  = (state == RUN) && !hit && !pause && frame_tick;
   assign game_state = state;

   // Next-frame scene: scroll/wrap every pipe and count score-line crossings.
   always_comb begin
      speed      = 11'(level) + 11'd1;
      gap_new    = 11'(GAP_BASE) - 11'(level) * 11'(GAP_STEP);
      pos_nxt    = pipe_pos;
      center_nxt = pipe_center;
      gap_nxt    = pipe_gap;
      cross_cnt  = '0;
      for (int i = 0; i < N_PIPES; i++) begin
         if (pipe_pos[11*i +: 11] >= speed) begin
            pos_nxt[11*i +: 11] = pipe_pos[11*i +: 11] - speed;
         end else begin
            pos_nxt[11*i +: 11]    = pipe_pos[11*i +: 11] + RING - speed;
            center_nxt[11*i +: 11] = 11'(CENTER_MIN) + {4'b0, lfsr[6:0] ^ 7'(i)};
            gap_nxt[11*i +: 11]    = gap_new;
         end
         if (pipe_pos[11*i +: 11] >= SCORE_X && pos_nxt[11*i +: 11] < SCORE_X) begin
            cross_cnt = cross_cnt + 4'd1;
         end
      end
      score_sum = {1'b0, score} + {5'b0, cross_cnt};
      score_nxt = score_sum[8] ? 8'hFF : score_sum[7:0];
   end

   // Bird physics: the position moves by the old velocity before the velocity updates.
   always_comb begin
      vel_inc = {vel[5], vel} + 7'(GRAVITY);
      if (flap_latch || flap) begin
         vel_nxt = FLAP_VEL;
      end else if (vel_inc > VMAX7) begin
         vel_nxt = VMAX7[5:0];
      end else begin
         vel_nxt = vel_inc[5:0];
      end
      bird_sum = {1'b0, bird_v} + {{6{vel[5]}}, vel};
      if (bird_sum[11]) begin
         bird_nxt = '0;
      end else if (bird_sum[10:0] > BIRD_MAX) begin
         bird_nxt = BIRD_MAX;
      end else begin
         bird_nxt = bird_sum[10:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end

      if (rst) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:    if (start) state <= RUN;
            RUN:     if (hit) state <= OVER;
                     else if (pause) state <= PAUSED;
            PAUSED:  if (!pause) state <= RUN;
            OVER:    if (start) state <= IDLE;
            default: state <= IDLE;
         endcase
      end

      // A start from IDLE rebuilds the scene exactly as reset does, minus the LFSR.
      if (reinit) begin
         pipe_pos    <= POS_INIT;
         pipe_center <= CENTER_INIT;
         pipe_gap    <= GAP_INIT;
         bird_v      <= 11'(BIRD_V0);
         bird_state  <= '0;
         score       <= '0;
         vel         <= '0;
         flap_latch  <= 1'b0;
         anim_cnt    <= '0;
      end else if (do_update) begin
         pipe_pos    <= pos_nxt;
         pipe_center <= center_nxt;
         pipe_gap    <= gap_nxt;
         score       <= score_nxt;
         bird_v      <= bird_nxt;
         vel         <= vel_nxt;
         flap_latch  <= 1'b0;
         if (anim_cnt == ANIM_LAST) begin
            anim_cnt   <= '0;
            bird_state <= {1'b0, bird_state[1:0] + 2'd1};
         end else begin
            anim_cnt <= anim_cnt + 1'b1;
         end
      end else if (flap) begin
         flap_latch <= 1'b1;
      end
   end

endmodule

// File: tb/tb_scene_animator.sv
// Directed bench for scene_animator: default build plus 5-pipe and 8-pipe builds
// for wide-bus scrolling, sprite cycling and score saturation.
module tb_scene_animator;

   logic clk = 1'b0;
   logic rst, frame_tick, start, start5, start8, pause, hit, flap;
   logic [1:0] level;

   logic [32:0] pipe_pos, pipe_center, pipe_gap;
   logic [10:0] bird_v;
   logic [2:0]  bird_state;
   logic [7:0]  score;
   logic [1:0]  game_state;

   logic [54:0] pos5, center5, gap5;
   logic [10:0] bird_v5;
   logic [2:0]  bird_state5;
   logic [7:0]  score5;
   logic [1:0]  game_state5;

   logic [87:0] pos8, center8, gap8;
   logic [10:0] bird_v8;
   logic [2:0]  bird_state8;
   logic [7:0]  score8;
   logic [1:0]  game_state8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   scene_animator dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
      .hit(hit), .flap(flap), .level(level), .pipe_pos(pipe_pos), .pipe_center(pipe_center),
      .pipe_gap(pipe_gap), .bird_v(bird_v), .bird_state(bird_state), .score(score),
      .game_state(game_state)
   );

   scene_animator #(.N_PIPES(5)) u5 (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start5), .pause(pause),
      .hit(hit), .flap(flap), .level(level), .pipe_pos(pos5), .pipe_center(center5),
      .pipe_gap(gap5), .bird_v(bird_v5), .bird_state(bird_state5), .score(score5),
      .game_state(game_state5)
   );

   scene_animator #(.N_PIPES(8), .PIPE_SPACING(50), .INIT_X(10)) u8 (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start8), .pause(pause),
      .hit(hit), .flap(flap), .level(level), .pipe_pos(pos8), .pipe_center(center8),
      .pipe_gap(gap8), .bird_v(bird_v8), .bird_state(bird_state8), .score(score8),
      .game_state(game_state8)
   );

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick(input logic with_flap);
      @(negedge clk);
      frame_tick = 1'b1;
      flap       = with_flap;
      @(negedge clk);
      frame_tick = 1'b0;
      flap       = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick(1'b0);
   endtask

   task automatic check_pipes(input string tag, input int p0, input int p1, input int p2);
      check_output({tag, "_pos0"}, 32'(pipe_pos[10:0]),  p0);
      check_output({tag, "_pos1"}, 32'(pipe_pos[21:11]), p1);
      check_output({tag, "_pos2"}, 32'(pipe_pos[32:22]), p2);
   endtask

   initial begin
      rst = 1'b1; frame_tick = 1'b0; start = 1'b0; start5 = 1'b0; start8 = 1'b0;
      pause = 1'b0; hit = 1'b0; flap = 1'b0; level = 2'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check_pipes("reset", 300, 500, 700);
      check_output("reset_center", 32'(pipe_center), {11'd184, 11'd184, 11'd184});
      check_output("reset_gap",    32'(pipe_gap),    {11'd100, 11'd100, 11'd100});
      check_output("reset_bird_v", 32'(bird_v), 150);
      check_output("reset_bstate", 32'(bird_state), 0);
      check_output("reset_score",  32'(score), 0);
      check_output("reset_gstate", 32'(game_state), 0);

      start = 1'b1; @(negedge clk); start = 1'b0;
      check_output("start_gstate", 32'(game_state), 1);
      check_pipes("start", 300, 500, 700);

      ticks(5);
      check_pipes("tick5", 295, 495, 695);
      check_output("tick5_bird_v", 32'(bird_v), 160);
      check_output("tick5_score",  32'(score), 0);

      // Latched flap, then gravity recovery
      flap = 1'b1; @(negedge clk); flap = 1'b0;
      tick(1'b0);
      check_output("flap_bird_v", 32'(bird_v), 165);
      tick(1'b0);
      check_output("flap_next1", 32'(bird_v), 157);
      tick(1'b0);
      check_output("flap_next2", 32'(bird_v), 150);
      tick(1'b0);
      check_output("flap_next3", 32'(bird_v), 144);
      tick(1'b1);
      check_output("flap_coincident", 32'(bird_v), 139);
      for (int k = 0; k < 17; k++) tick(1'b1);
      check_output("climb_near_top", 32'(bird_v), 3);
      tick(1'b1);
      check_output("clamp_top", 32'(bird_v), 0);

      ticks(57);
      check_output("fall_vel_cap", 32'(bird_v), 435);
      tick(1'b0);
      check_output("clamp_bottom", 32'(bird_v), 440);
      tick(1'b0);
      check_output("clamp_bottom_hold", 32'(bird_v), 440);
      check_pipes("tick87", 213, 413, 613);
      check_output("tick87_bstate", 32'(bird_state), 2);

      pause = 1'b1; @(negedge clk);
      check_output("pause_gstate", 32'(game_state), 2);
      ticks(10);
      check_output("paused_gstate", 32'(game_state), 2);
      check_pipes("paused", 213, 413, 613);
      check_output("paused_bird_v", 32'(bird_v), 440);
      check_output("paused_bstate", 32'(bird_state), 2);
      check_output("paused_score",  32'(score), 0);
      pause = 1'b0; @(negedge clk);
      check_output("resume_gstate", 32'(game_state), 1);
      tick(1'b0);
      check_pipes("resume", 212, 412, 612);

      ticks(11);
      check_output("score_at_201", 32'(score), 0);
      check_output("pos_201", 32'(pipe_pos[10:0]), 201);
      tick(1'b0);
      check_output("score_at_200", 32'(score), 0);
      tick(1'b0);
      check_output("score_at_199", 32'(score), 1);
      check_pipes("tick101", 199, 399, 599);

      hit = 1'b1; pause = 1'b1; @(negedge clk); hit = 1'b0; pause = 1'b0;
      check_output("hit_pause_gstate", 32'(game_state), 3);
      tick(1'b0);
      check_output("over_hold_pos", 32'(pipe_pos[10:0]), 199);
      check_output("over_hold_score", 32'(score), 1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check_output("over_to_idle", 32'(game_state), 0);
      check_output("idle_hold_pos", 32'(pipe_pos[10:0]), 199);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check_output("restart_gstate", 32'(game_state), 1);
      check_pipes("restart", 300, 500, 700);
      check_output("restart_bird_v", 32'(bird_v), 150);
      check_output("restart_score",  32'(score), 0);
      check_output("restart_bstate", 32'(bird_state), 0);

      // Wrap at level 3 with a coincident score crossing on pipe 1
      ticks(2);
      level = 2'd3;
      ticks(74);
      check_pipes("prewrap", 2, 202, 402);
      check_output("prewrap_score", 32'(score), 1);
      tick(1'b0);
      check_pipes("wrap", 598, 198, 398);
      check_output("wrap_score", 32'(score), 2);
      check_output("wrap_gap0", 32'(pipe_gap[10:0]), 52);
      check_output("wrap_center0_range",
                   32'(pipe_center[10:0] >= 11'd120 && pipe_center[10:0] <= 11'd247), 1);
      check_output("wrap_gap1",    32'(pipe_gap[21:11]), 100);
      check_output("wrap_center1", 32'(pipe_center[21:11]), 184);

      hit = 1'b1; frame_tick = 1'b1; @(negedge clk); hit = 1'b0; frame_tick = 1'b0;
      check_output("hit_tick_gstate", 32'(game_state), 3);
      check_pipes("hit_tick", 598, 198, 398);
      start = 1'b1; @(negedge clk); start = 1'b0;
      check_output("idle_again", 32'(game_state), 0);
      start = 1'b1; frame_tick = 1'b1; @(negedge clk); start = 1'b0; frame_tick = 1'b0;
      check_output("start_tick_gstate", 32'(game_state), 1);
      check_pipes("start_tick", 300, 500, 700);
      check_output("start_tick_gap0", 32'(pipe_gap[10:0]), 100);
      check_output("start_tick_score", 32'(score), 0);

      hit = 1'b1; @(negedge clk); hit = 1'b0;

      // Five-pipe build
      level = 2'd0;
      start5 = 1'b1; @(negedge clk); start5 = 1'b0;
      ticks(12);
      check_output("n5_gstate", 32'(game_state5), 1);
      check_output("n5_pos0", 32'(pos5[10:0]),  288);
      check_output("n5_pos1", 32'(pos5[21:11]), 488);
      check_output("n5_pos2", 32'(pos5[32:22]), 688);
      check_output("n5_pos3", 32'(pos5[43:33]), 888);
      check_output("n5_pos4", 32'(pos5[54:44]), 1088);
      check_output("n5_bstate", 32'(bird_state5), 2);

      // Eight-pipe build driven to score saturation
      level = 2'd3;
      start8 = 1'b1; @(negedge clk); start8 = 1'b0;
      ticks(3400);
      check_output("n8_score_sat", 32'(score8), 255);
      ticks(200);
      check_output("n8_score_hold", 32'(score8), 255);
      check_output("n8_gstate", 32'(game_state8), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
